// File: rtl/func_sweep_checker.sv
// Pipelined WIDTH-lane evaluator of y = (~b & ~c) | (a & ~b) with a built-in
// eight-beat self-test sweep that checks each result against a programmable truth table.
module func_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             start,
  input  logic [7:0]       tt_ref,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       first_fail_k
);

  localparam int DW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     k_q;
  logic [DW-1:0]  drain_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SWEEP;
      SWEEP:   if (k_q == 3'd7) state_d = DRAIN;
      DRAIN:   if (drain_q == DW'(STAGES - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= (state_q == SWEEP) ? k_q + 3'd1 : '0;
      drain_q <= (state_q == DRAIN) ? drain_q + DW'(1) : '0;
    end
  end

  logic [WIDTH-1:0] a_in, b_in, c_in, y_in;
  logic             v_in, chk_in;
  logic [2:0]       idx_in;

  // Sweep overrides the lane inputs; streaming beats lose to a same-cycle start.
  always_comb begin
    a_in   = a;
    b_in   = b;
    c_in   = c;
    v_in   = 1'b0;
    chk_in = 1'b0;
    idx_in = '0;
    if (state_q == SWEEP) begin
      v_in   = 1'b1;
      chk_in = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        idx_in  = k_q + 3'(i);
        a_in[i] = idx_in[2];
        b_in[i] = idx_in[1];
        c_in[i] = idx_in[0];
      end
    end else if (state_q == IDLE) begin
      v_in = in_valid & ~start;
    end
    y_in = (~b_in & ~c_in) | (a_in & ~b_in);
  end

  logic             pv [STAGES];
  logic             pc [STAGES];
  logic [2:0]       pk [STAGES];
  logic [WIDTH-1:0] py [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        pv[s] <= 1'b0;
        pc[s] <= 1'b0;
        pk[s] <= '0;
        py[s] <= '0;
      end
    end else begin
      pv[0] <= v_in;
      pc[0] <= chk_in;
      pk[0] <= k_q;
      py[0] <= y_in;
      for (int unsigned s = 1; s < STAGES; s++) begin
        pv[s] <= pv[s-1];
        pc[s] <= pc[s-1];
        pk[s] <= pk[s-1];
        py[s] <= py[s-1];
      end
    end
  end

  assign y         = py[STAGES-1];
  assign out_valid = pv[STAGES-1];
  assign busy      = (state_q == SWEEP) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

  logic       mismatch;
  logic [2:0] idx_out;

  // Lane index is rebuilt from the carried k rather than piped per lane.
  always_comb begin
    mismatch = 1'b0;
    idx_out  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      idx_out = pk[STAGES-1] + 3'(i);
      if (py[STAGES-1][i] != tt_ref[idx_out]) mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt      <= '0;
      fail_valid   <= 1'b0;
      first_fail_k <= '0;
    end else if (state_q == IDLE && start) begin
      err_cnt      <= '0;
      fail_valid   <= 1'b0;
      first_fail_k <= '0;
    end else if (pv[STAGES-1] && pc[STAGES-1] && mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (!fail_valid) begin
        fail_valid   <= 1'b1;
        first_fail_k <= pk[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_func_sweep_checker.sv
// Directed bench for func_sweep_checker: streaming, sweeps, in-flight beats,
// mid-sweep reset and error-counter saturation.
module tb_func_sweep_checker;

  logic       clk = 1'b0;
  logic       rst, in_valid, start;
  logic [3:0] a, b, c;
  logic [7:0] tt_ref;

  logic [3:0] y, y2;
  logic       out_valid, busy, done, fail_valid;
  logic       out_valid2, busy2, done2, fail_valid2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [2:0] first_fail_k, first_fail_k2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  func_sweep_checker #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .start(start), .tt_ref(tt_ref), .y(y), .out_valid(out_valid),
    .busy(busy), .done(done), .err_cnt(err_cnt), .fail_valid(fail_valid),
    .first_fail_k(first_fail_k)
  );

  func_sweep_checker #(.WIDTH(4), .STAGES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .start(start), .tt_ref(tt_ref), .y(y2), .out_valid(out_valid2),
    .busy(busy2), .done(done2), .err_cnt(err_cnt2), .fail_valid(fail_valid2),
    .first_fail_k(first_fail_k2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected y for tt 0x31, k = 0..7, lane i sees idx (k+i) mod 8.
  logic [3:0] exp_y [8] = '{4'b0001, 4'b1000, 4'b1100, 4'b0110,
                            4'b0011, 4'b1001, 4'b0100, 4'b0010};

  initial begin
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    a = '0; b = '0; c = '0; tt_ref = 8'h31;
    repeat (2) tick();
    check("rst_y", 32'(y), 0);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_cnt), 0);
    check("rst_fail", 32'(fail_valid), 0);
    check("rst_ffk", 32'(first_fail_k), 0);
    rst = 1'b0;
    tick();

    // Streaming beat
    a = 4'b1010; b = 4'b0000; c = 4'b0110; in_valid = 1'b1;
    check("str_ov_c0", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    check("str_ov_c1", 32'(out_valid), 0);
    tick();
    check("str_ov_c2", 32'(out_valid), 1);
    check("str_y_c2", 32'(y), 32'b1011);
    tick();
    check("str_ov_c3", 32'(out_valid), 0);
    tick();

    // Clean sweep, tt 0x31
    tt_ref = 8'h31; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cy = 1; cy <= 12; cy++) begin
      check($sformatf("sw31_busy_c%0d", cy), 32'(busy), 32'(cy >= 1 && cy <= 10));
      check($sformatf("sw31_done_c%0d", cy), 32'(done), 32'(cy == 11));
      check($sformatf("sw31_ov_c%0d", cy), 32'(out_valid), 32'(cy >= 3 && cy <= 10));
      if (cy >= 3 && cy <= 10)
        check($sformatf("sw31_y_c%0d", cy), 32'(y), 32'(exp_y[cy-3]));
      tick();
    end
    check("sw31_err", 32'(err_cnt), 0);
    check("sw31_fail", 32'(fail_valid), 0);

    // Sweep with bit 0 flipped
    tt_ref = 8'h30; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cy = 1; cy <= 12; cy++) begin
      if (cy == 3) check("sw30_err_c3", 32'(err_cnt), 0);
      if (cy == 4) begin
        check("sw30_err_c4", 32'(err_cnt), 1);
        check("sw30_fail_c4", 32'(fail_valid), 1);
      end
      tick();
    end
    check("sw30_err", 32'(err_cnt), 4);
    check("sw30_fail", 32'(fail_valid), 1);
    check("sw30_ffk", 32'(first_fail_k), 0);

    // Streaming beat in flight when start is accepted
    tt_ref = 8'h31;
    a = 4'b1111; b = 4'b0000; c = 4'b0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b1;
    tick();
    for (int cy = 2; cy <= 14; cy++) begin
      start    = (cy == 4);
      in_valid = (cy >= 4 && cy <= 11);
      check($sformatf("fl_ov_c%0d", cy), 32'(out_valid), 32'(cy == 2 || (cy >= 4 && cy <= 11)));
      check($sformatf("fl_done_c%0d", cy), 32'(done), 32'(cy == 12));
      check($sformatf("fl_busy_c%0d", cy), 32'(busy), 32'(cy >= 2 && cy <= 11));
      if (cy == 2) check("fl_y_c2", 32'(y), 32'b1111);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    check("fl_err", 32'(err_cnt), 0);
    check("fl_fail", 32'(fail_valid), 0);

    // Reset in cycle 5 of a sweep
    tt_ref = 8'h30; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cy = 1; cy <= 5; cy++) begin
      if (cy == 4) check("rs_err_c4", 32'(err_cnt), 1);
      if (cy == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    check("rs_y_c6", 32'(y), 0);
    check("rs_ov_c6", 32'(out_valid), 0);
    check("rs_busy_c6", 32'(busy), 0);
    check("rs_done_c6", 32'(done), 0);
    check("rs_err_c6", 32'(err_cnt), 0);
    check("rs_fail_c6", 32'(fail_valid), 0);
    check("rs_ffk_c6", 32'(first_fail_k), 0);
    for (int cy = 6; cy <= 18; cy++) begin
      check($sformatf("rs_nodone_c%0d", cy), 32'(done), 0);
      check($sformatf("rs_nobusy_c%0d", cy), 32'(busy), 0);
      tick();
    end
    tt_ref = 8'h31; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cy = 1; cy <= 12; cy++) begin
      check($sformatf("rs2_done_c%0d", cy), 32'(done), 32'(cy == 11));
      tick();
    end
    check("rs2_err", 32'(err_cnt), 0);

    // Every beat mismatches: CNT_W=2 saturates
    tt_ref = 8'hCE; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("sat_err8", 32'(err_cnt), 8);
    check("sat_ffk8", 32'(first_fail_k), 0);
    check("sat_err2", 32'(err_cnt2), 3);
    check("sat_fail2", 32'(fail_valid2), 1);
    check("sat_ffk2", 32'(first_fail_k2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
